// File: rtl/microwave_controller_if.sv
// ----------------------------------------------------------------------------
// microwave_controller_if
//   Groups the oven sequencer's keypad/button/door inputs and its
//   display/status outputs.
//   master: keypad encoder / front panel side (drives D, loadn, pgt_1Hz,
//           Startn, Stopn, Clearn, door_closed; observes the outputs)
//   slave : microwave_controller (consumes the inputs; drives sec_ones,
//           sec_tens, min_ones, mag_on, done, state)
// ----------------------------------------------------------------------------
interface microwave_controller_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       Startn;
    logic       Stopn;
    logic       Clearn;
    logic       door_closed;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    modport master (
        output D, loadn, pgt_1Hz, Startn, Stopn, Clearn, door_closed,
        input  sec_ones, sec_tens, min_ones, mag_on, done, state
    );

    modport slave (
        input  D, loadn, pgt_1Hz, Startn, Stopn, Clearn, door_closed,
        output sec_ones, sec_tens, min_ones, mag_on, done, state
    );
endinterface

// File: rtl/microwave_controller.sv
// ----------------------------------------------------------------------------
// microwave_controller
//   Main sequencer of the oven. Detects edges on the digit strobe, the 1 Hz
//   tick and the Start/Stop/Clear buttons, holds the M:SS BCD cook time and
//   runs the IDLE/ENTRY/COOK/PAUSE/DONE state machine.
//   Ports:
//     Clk    - system clock, rising edge
//     Resetn - asynchronous active-low reset
//     bus    - slave side of microwave_controller_if (inputs D, loadn,
//              pgt_1Hz, Startn, Stopn, Clearn, door_closed; outputs
//              sec_ones, sec_tens, min_ones, mag_on, done, state)
//   Parameter DONE_TICKS: ticks the done indicator stays up before IDLE.
// ----------------------------------------------------------------------------
module microwave_controller #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    microwave_controller_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DONE_TICKS + 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StEntry = 3'd1,
        StCook  = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic [CntW-1:0] done_cnt_q, done_cnt_d;
    logic            mag_on_q, done_q;

    // Previous samples for edge detection
    logic loadn_q, startn_q, stopn_q, clearn_q, pgt_q;

    logic load_ev, start_ev, stop_ev, clear_ev, tick_ev, load_ok;
    logic time_zero;

    logic [3:0] dec_ones, dec_tens, dec_min;
    logic       dec_zero;

    assign load_ev  = loadn_q  & ~bus.loadn;
    assign start_ev = startn_q & ~bus.Startn;
    assign stop_ev  = stopn_q  & ~bus.Stopn;
    assign clear_ev = clearn_q & ~bus.Clearn;
    assign tick_ev  = ~pgt_q   &  bus.pgt_1Hz;

    // Digits above 9 are not BCD and are dropped
    assign load_ok  = load_ev & (bus.D <= 4'd9);

    assign time_zero = (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    // One-second countdown with borrow through the BCD digits
    always_comb begin
        dec_ones = sec_ones_q;
        dec_tens = sec_tens_q;
        dec_min  = min_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_ones = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_tens = sec_tens_q - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_min  = min_ones_q - 4'd1;
            dec_tens = 4'd5;
            dec_ones = 4'd9;
        end
    end

    assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            StIdle: begin
                if (clear_ev) begin
                    {min_ones_d, sec_tens_d, sec_ones_d} = 12'h000;
                end else if (load_ok) begin
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = bus.D;
                    state_d    = StEntry;
                end
            end

            StEntry: begin
                if (clear_ev || stop_ev) begin
                    {min_ones_d, sec_tens_d, sec_ones_d} = 12'h000;
                    state_d = StIdle;
                end else if (start_ev && bus.door_closed && !time_zero) begin
                    state_d = StCook;
                end else if (load_ok) begin
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = bus.D;
                end
            end

            StCook: begin
                if (clear_ev) begin
                    {min_ones_d, sec_tens_d, sec_ones_d} = 12'h000;
                    state_d = StIdle;
                end else if (stop_ev) begin
                    state_d = StPause;
                end else begin
                    // The tick still counts down even if the door opens on the same edge
                    if (tick_ev) begin
                        min_ones_d = dec_min;
                        sec_tens_d = dec_tens;
                        sec_ones_d = dec_ones;
                    end
                    if (tick_ev && dec_zero) begin
                        state_d    = StDone;
                        done_cnt_d = '0;
                    end else if (!bus.door_closed) begin
                        state_d = StPause;
                    end
                end
            end

            StPause: begin
                if (stop_ev || clear_ev) begin
                    {min_ones_d, sec_tens_d, sec_ones_d} = 12'h000;
                    state_d = StIdle;
                end else if (start_ev && bus.door_closed) begin
                    state_d = StCook;
                end
            end

            StDone: begin
                if (clear_ev || stop_ev) begin
                    state_d    = StIdle;
                    done_cnt_d = '0;
                end else if (load_ok) begin
                    // Time is 0:00 here, so the shift leaves only the new digit
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = bus.D;
                    state_d    = StEntry;
                    done_cnt_d = '0;
                end else if (tick_ev) begin
                    if (done_cnt_q + CntW'(1) == CntW'(DONE_TICKS)) begin
                        state_d    = StIdle;
                        done_cnt_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q + CntW'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
                {min_ones_d, sec_tens_d, sec_ones_d} = 12'h000;
                done_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= StIdle;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            done_cnt_q <= '0;
            mag_on_q   <= 1'b0;
            done_q     <= 1'b0;
            loadn_q    <= 1'b1;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            clearn_q   <= 1'b1;
            pgt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            done_cnt_q <= done_cnt_d;
            mag_on_q   <= (state_d == StCook);
            done_q     <= (state_d == StDone);
            loadn_q    <= bus.loadn;
            startn_q   <= bus.Startn;
            stopn_q    <= bus.Stopn;
            clearn_q   <= bus.Clearn;
            pgt_q      <= bus.pgt_1Hz;
        end
    end

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.mag_on   = mag_on_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule
